// File: rtl/bram_pkg.sv
// -----------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the block-RAM stream reader.
//   DEF_ADDR_W / DEF_DATA_W   default RAM geometry (64 x 8)
//   DEF_FIFO_DEPTH            default return-data buffer depth
//   rd_state_t                reader FSM encoding
//   fifo_cnt_w()              width of a 0..depth occupancy counter
// -----------------------------------------------------------------------------
package bram_pkg;

   localparam int DEF_ADDR_W     = 6;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rd_state_t;

   // Occupancy must represent both 0 and depth, hence depth+1 values.
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int DEF_FIFO_CNT_W = fifo_cnt_w(DEF_FIFO_DEPTH);

endpackage

// File: rtl/rd_skid_fifo.sv
// -----------------------------------------------------------------------------
// rd_skid_fifo
// Small synchronous FIFO holding returned RAM words plus their last-beat flag.
// The head entry is presented combinationally, so it stays stable until popped.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push         write push_data/push_last at the tail
//   pop          drop the head entry (caller guarantees count != 0)
//   count        current occupancy, 0..DEPTH
//   head_data    data of the oldest entry (0 after reset)
//   head_last    last flag of the oldest entry
// Push and pop in the same cycle on a full FIFO is legal: the head is read
// before the edge and the freed slot is written at the edge.
// -----------------------------------------------------------------------------
module rd_skid_fifo
   import bram_pkg::*;
#(
   parameter int DEPTH  = DEF_FIFO_DEPTH,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_FIFO_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              push_last,
   input  logic              pop,
   output logic [CNT_W-1:0]  count,
   output logic [DATA_W-1:0] head_data,
   output logic              head_last
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]  last_mem;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         last_mem <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_mem[i] <= '0;
         end
      end else begin
         if (push) begin
            data_mem[wr_ptr] <= push_data;
            last_mem[wr_ptr] <= push_last;
            wr_ptr           <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_data = data_mem[rd_ptr];
   assign head_last = last_mem[rd_ptr];

endmodule

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
// Read-side master for a synchronous block RAM (1-cycle read latency).
// Takes a (start_addr, length) command, issues sequential reads (address wraps
// modulo 2**ADDR_W) and returns the words as a byte stream with a last flag.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  command strobe, sampled only while busy=0
//   start_addr, length     first address, beat count (0..2**ADDR_W)
//   busy                   command in progress (state != IDLE)
//   done                   one-cycle pulse at command completion
//   mem_en, mem_addr       RAM read port request
//   mem_rdata              RAM data, valid the cycle after mem_en
//   m_valid, m_data,       output stream
//   m_last, m_ready
//   state_dbg              current FSM state
//   checksum               (only with READ_CHECKSUM_EN) XOR of accepted beats
// Optional feature macro: READ_CHECKSUM_EN.
//
// Stream handshake: a beat transfers on a rising edge where m_valid and
// m_ready are both 1. Once m_valid is raised it stays high, with m_data and
// m_last unchanged, until that transfer happens; m_ready may change freely.
// -----------------------------------------------------------------------------
module bram_stream_reader
   import bram_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH   // must be >= 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready,
   output rd_state_t         state_dbg
`ifdef READ_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);
   localparam logic [ADDR_W:0] ONE_BEAT = (ADDR_W+1)'(1);

   rd_state_t         state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic              inflight;
   logic              inflight_last;
   logic [CNT_W-1:0]  count;
   logic              pop;
   logic              credit_ok;
   logic              issue;

   assign pop = m_valid & m_ready;

   // A read may be issued only if its data is guaranteed a FIFO slot when it
   // returns next cycle: free slots, minus the read already in flight, plus the
   // slot freed by a pop happening this cycle.
   assign credit_ok = (FIFO_DEPTH - int'(count) - int'(inflight) + int'(pop)) > 0;
   assign issue     = (state == READ) && credit_ok && (remaining != '0);

   assign mem_en    = issue;
   assign mem_addr  = addr;
   assign busy      = (state != IDLE);
   assign m_valid   = (count != '0);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         addr          <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         done          <= 1'b0;
      end else begin
         done          <= 1'b0;
         // Whatever is issued now returns next cycle and is pushed blindly.
         inflight      <= issue;
         inflight_last <= issue && (remaining == ONE_BEAT);
         case (state)
            IDLE: begin
               if (start) begin
                  addr      <= start_addr;
                  remaining <= length;
                  if (length == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (issue) begin
                  addr      <= addr + 1'b1;   // natural wrap at 2**ADDR_W
                  remaining <= remaining - 1'b1;
                  if (remaining == ONE_BEAT) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && m_last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   rd_skid_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data (mem_rdata),
      .push_last (inflight_last),
      .pop       (pop),
      .count     (count),
      .head_data (m_data),
      .head_last (m_last)
   );

`ifdef READ_CHECKSUM_EN
   // Cleared when a command is accepted; holds its final value through the
   // done pulse and the following idle time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if ((state == IDLE) && start) begin
         checksum <= '0;
      end else if (pop) begin
         checksum <= checksum ^ m_data;
      end
   end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;
   import bram_pkg::*;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   always #5 clk = ~clk;

   logic       start;
   logic [5:0] start_addr;
   logic [6:0] length;
   logic       busy;
   logic       done;
   logic       mem_en;
   logic [5:0] mem_addr;
   logic [7:0] mem_rdata;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_last;
   logic       m_ready;
   rd_state_t  state_dbg;
`ifdef READ_CHECKSUM_EN
   logic [7:0] checksum;
`endif

   bram_stream_reader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .mem_en     (mem_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_last     (m_last),
      .m_ready    (m_ready),
      .state_dbg  (state_dbg)
`ifdef READ_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   // RAM model: 64 x 8, one-cycle read latency
   logic [7:0] ram [64];
   always @(posedge clk) begin
      if (mem_en) mem_rdata <= ram[mem_addr];
   end

   // ---------------- scoreboard ----------------
   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_q[$];        // {last, data}
   logic [5:0] exp_addr_q[$];
   logic [7:0] exp_ck;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int addr, input int len);
      logic [5:0] a;
      exp_ck = '0;
      for (int i = 0; i < len; i++) begin
         a = 6'((addr + i) % 64);
         exp_addr_q.push_back(a);
         exp_q.push_back({(i == len - 1), ram[a]});
         exp_ck = exp_ck ^ ram[a];
      end
   endtask

   // Monitor: samples on the falling edge, i.e. the values seen by the next rising edge.
   int         outstanding;
   logic       prev_stall;
   logic [8:0] prev_beat;
   logic       prev_last_acc;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_addr_q.delete();
         outstanding   = 0;
         prev_stall    = 1'b0;
         prev_beat     = '0;
         prev_last_acc = 1'b0;
      end else begin
         if (prev_last_acc) chk("done_after_last", done, 1);
         if (prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_beat", {m_last, m_data}, prev_beat);
         end
         if (mem_en) begin
            chk("addr_expected", (exp_addr_q.size() != 0), 1);
            if (exp_addr_q.size() != 0) chk("mem_addr", mem_addr, exp_addr_q.pop_front());
            outstanding++;
         end
         if (m_valid && m_ready) begin
            chk("beat_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("beat", {m_last, m_data}, exp_q.pop_front());
            outstanding--;
         end
         if (m_valid && !m_ready) chk("buffered_le_depth", (outstanding <= 2), 1);
         prev_stall    = m_valid && !m_ready;
         prev_beat     = {m_last, m_data};
         prev_last_acc = m_valid && m_ready && m_last;
      end
   end

   // ---------------- driver ----------------
   // Runs one command from a point just after a rising edge. m_ready is low on
   // loop cycles lo..hi; on cycle ign a stray start with other arguments is
   // pulsed. exp_cycles < 0 skips the latency check.
   task automatic run_cmd(input int addr, input int len, input int lo, input int hi,
                          input int ign, input int exp_cycles);
      int got;
      int cycles;
      got    = 0;
      cycles = -1;
      push_exp(addr, len);
      start      = 1'b1;
      start_addr = 6'(addr);
      length     = 7'(len);
      m_ready    = !(0 >= lo && 0 <= hi);
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (done) begin
            got    = 1;
            cycles = cyc;
`ifdef READ_CHECKSUM_EN
            chk("checksum", checksum, exp_ck);
`endif
            break;
         end
         @(posedge clk);
         #1;
         start   = ((cyc + 1) == ign);
         if ((cyc + 1) == ign) begin
            start_addr = 6'd40;
            length     = 7'd3;
         end
         m_ready = !((cyc + 1) >= lo && (cyc + 1) <= hi);
      end
      chk("done_seen", got, 1);
      if (exp_cycles >= 0) chk("done_latency", cycles, exp_cycles);
      @(posedge clk);
      #1;
      start   = 1'b0;
      m_ready = 1'b1;
      chk("beats_left", exp_q.size(), 0);
      chk("addrs_left", exp_addr_q.size(), 0);
      chk("idle_after_done", {busy, state_dbg}, {1'b0, IDLE});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int got;
      rst_n      = 1'b0;
      start      = 1'b0;
      start_addr = '0;
      length     = '0;
      m_ready    = 1'b1;
      for (int i = 0; i < 64; i++) ram[i] = 8'(i);

      // reset state
      @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_state", state_dbg, IDLE);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic: addr 4, length 3, explicit latency checks
      push_exp(4, 3);
      start      = 1'b1;
      start_addr = 6'd4;
      length     = 7'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("lat_mem_en", mem_en, 1);
      chk("lat_mem_addr", mem_addr, 4);
      chk("lat_busy", busy, 1);
      chk("lat_state", state_dbg, READ);
      chk("lat_valid_e0", m_valid, 0);
      @(negedge clk);
      chk("lat_valid_e1", m_valid, 0);
      @(negedge clk);
      chk("lat_valid_e2", m_valid, 1);
      chk("lat_first_data", m_data, 8'h04);
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            break;
         end
      end
      chk("basic_done", got, 1);
      @(posedge clk);
      #1;
      chk("basic_beats_left", exp_q.size(), 0);

      // wrap across the top of memory
      run_cmd(62, 4, -1, -2, -1, 7);

      // zero length: no reads, no beats, done the cycle after acceptance
      run_cmd(5, 0, -1, -2, -1, 1);

      // stray start while busy
      run_cmd(20, 6, -1, -2, 2, 9);

      // random contents from here on
      for (int i = 0; i < 64; i++) ram[i] = 8'($urandom_range(0, 255));

      // full length at one beat per cycle
      run_cmd(0, 64, -1, -2, -1, 67);

      // backpressure on cycles 3..10
      run_cmd(8, 8, 3, 10, -1, -1);

      // random stall window
      run_cmd($urandom_range(0, 63), $urandom_range(5, 20), $urandom_range(2, 6),
              $urandom_range(7, 14), -1, -1);

      // reset in the middle of READ
      push_exp(0, 20);
      start      = 1'b1;
      start_addr = 6'd0;
      length     = 7'd20;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_mem_en", mem_en, 0);
      @(posedge clk);
      #1;
      chk("mid_rst_busy_next", busy, 0);
      chk("mid_rst_valid_next", m_valid, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_cmd(10, 5, -1, -2, -1, 8);

      // checksum bytes 0x5A ^ 0x3C ^ 0xFF = 0x99
      ram[30] = 8'h5A;
      ram[31] = 8'h3C;
      ram[32] = 8'hFF;
      run_cmd(30, 3, -1, -2, -1, 6);
`ifdef READ_CHECKSUM_EN
      chk("checksum_hold", checksum, 8'h99);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
